// File: rtl/seq_multiplier.sv
// seq_multiplier: multi-cycle signed WIDTH x WIDTH multiplier.
// Sign-magnitude shift-add, one multiplier bit per clock, full 2*WIDTH
// signed product plus a WIDTH-bit signed overflow flag.
// Optional feature macro: MULT_EARLY_EXIT_EN (leave RUN once the
// remaining multiplier bits are all zero).
module seq_multiplier #(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] prod_o,
    output logic [WIDTH-1:0] prod_hi_o,
    output logic             ovf_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 neg_q, neg_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     prod_q, prod_d;
    logic [WIDTH-1:0]     prod_hi_q, prod_hi_d;
    logic                 ovf_q, ovf_d;

    logic                 load, step, fix, early_exit;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [2*WIDTH-1:0]   fixed_res;

    // Magnitudes are plain unsigned; the most-negative value maps onto
    // 2^(WIDTH-1) naturally, so no special case is needed.
    assign mag_a = a_i[WIDTH-1] ? (~a_i + WIDTH'(1)) : a_i;
    assign mag_b = b_i[WIDTH-1] ? (~b_i + WIDTH'(1)) : b_i;
    assign fixed_res = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;

`ifdef MULT_EARLY_EXIT_EN
    assign early_exit = (mplier_q == '0);
`else
    assign early_exit = 1'b0;
`endif

    // State register plus datapath registers, synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            neg_q     <= 1'b0;
            done_q    <= 1'b0;
            prod_q    <= '0;
            prod_hi_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            neg_q     <= neg_d;
            done_q    <= done_d;
            prod_q    <= prod_d;
            prod_hi_q <= prod_hi_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN -> FIX on last bit
    // (or early exit), FIX -> IDLE after one edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_i) state_d = RUN;
            RUN:  if (early_exit || count_q == LAST) state_d = FIX;
            FIX:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: datapath strobes and the busy flag.
    always_comb begin
        load   = (state_q == IDLE) && start_i;
        step   = (state_q == RUN) && !early_exit;
        fix    = (state_q == FIX);
        busy_o = (state_q != IDLE);
    end

    // Datapath next-state: operand load, shift-add step, sign fix.
    always_comb begin
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        neg_d     = neg_q;
        prod_d    = prod_q;
        prod_hi_d = prod_hi_q;
        ovf_d     = ovf_q;
        done_d    = fix;
        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, mag_a};
            mplier_d = mag_b;
            acc_d    = '0;
            count_d  = '0;
            neg_d    = a_i[WIDTH-1] ^ b_i[WIDTH-1];
        end
        if (step) begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CW'(1);
        end
        if (fix) begin
            prod_d    = fixed_res[WIDTH-1:0];
            prod_hi_d = fixed_res[2*WIDTH-1:WIDTH];
            // Overflow is judged on the sign-corrected full product.
            ovf_d     = (fixed_res[2*WIDTH-1:WIDTH] != {WIDTH{fixed_res[WIDTH-1]}});
        end
    end

    assign done_o    = done_q;
    assign prod_o    = prod_q;
    assign prod_hi_o = prod_hi_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier against an arithmetic model.
module tb_seq_multiplier;

    localparam int W = 64;
    localparam logic signed [127:0] MAXS = 128'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [127:0] MINS = -128'sh8000_0000_0000_0000;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [W-1:0]  a, b;
    logic          busy, done, ovf;
    logic [W-1:0]  prod, prod_hi;

    int n_cmp = 0;
    int n_err = 0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b),
        .busy_o(busy), .done_o(done), .prod_o(prod), .prod_hi_o(prod_hi),
        .ovf_o(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Full signed product from plain wide arithmetic.
    function automatic logic [127:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [127:0] ex, ey;
        ex = $signed(x);
        ey = $signed(y);
        return ex * ey;
    endfunction

    function automatic logic ref_ovf(input logic [127:0] p);
        logic signed [127:0] sp;
        sp = p;
        return (sp > MAXS) || (sp < MINS);
    endfunction

    // Clocks from the start edge to the done cycle.
    function automatic int ref_lat(input logic [W-1:0] y);
`ifdef MULT_EARLY_EXIT_EN
        logic [W-1:0] mag;
        int len;
        mag = y[W-1] ? (~y + 64'd1) : y;
        len = 0;
        for (int i = 0; i < W; i++) if (mag[i]) len = i + 1;
        return (len == W) ? W + 1 : len + 2;
`else
        return (y == y) ? W + 1 : 0;
`endif
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 9))
            0: return 64'd0;
            1: return 64'd1;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'h7FFF_FFFF_FFFF_FFFF;
            5: return {32'd0, $urandom()};
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // Launch one operation from an idle cycle (#1 after a posedge) and wait
    // for done; operands are scrambled right after acceptance.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         output int lat, output int busy_bad);
        a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = {$urandom(), $urandom()};
        b = {$urandom(), $urandom()};
        lat = 0; busy_bad = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy !== 1'b1) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        if (done === 1'b1 && busy !== 1'b0) busy_bad++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = 64'd3; b = 64'd5;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if ({prod_hi, prod} !== 128'd0) begin n_err++; $display("FAIL reset_prod got %h want 0", {prod_hi, prod}); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_start_masked busy got %b want 0", busy); end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[7], tb_[7], ep[7], eh[7];
        logic         eo[7];
        int lat, bb;
        ta[0] = 64'd3;                  tb_[0] = 64'd5;
        ep[0] = 64'd15;                 eh[0] = 64'd0;                   eo[0] = 1'b0;
        ta[1] = -64'sd7;                tb_[1] = 64'd6;
        ep[1] = 64'hFFFF_FFFF_FFFF_FFD6; eh[1] = 64'hFFFF_FFFF_FFFF_FFFF; eo[1] = 1'b0;
        ta[2] = -64'sd7;                tb_[2] = -64'sd6;
        ep[2] = 64'd42;                 eh[2] = 64'd0;                   eo[2] = 1'b0;
        ta[3] = 64'h1_0000_0000;        tb_[3] = 64'h1_0000_0000;
        ep[3] = 64'd0;                  eh[3] = 64'd1;                   eo[3] = 1'b1;
        ta[4] = 64'h8000_0000_0000_0000; tb_[4] = 64'hFFFF_FFFF_FFFF_FFFF;
        ep[4] = 64'h8000_0000_0000_0000; eh[4] = 64'd0;                  eo[4] = 1'b1;
        ta[5] = 64'h8000_0000_0000_0000; tb_[5] = 64'h8000_0000_0000_0000;
        ep[5] = 64'd0;                  eh[5] = 64'h4000_0000_0000_0000; eo[5] = 1'b1;
        ta[6] = 64'h1234_5678_9ABC_DEF0; tb_[6] = 64'd0;
        ep[6] = 64'd0;                  eh[6] = 64'd0;                   eo[6] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            do_op(ta[i], tb_[i], lat, bb);
            n_cmp++; if (prod !== ep[i]) begin n_err++; $display("FAIL dir%0d_prod got %h want %h", i, prod, ep[i]); end
            n_cmp++; if (prod_hi !== eh[i]) begin n_err++; $display("FAIL dir%0d_prod_hi got %h want %h", i, prod_hi, eh[i]); end
            n_cmp++; if (ovf !== eo[i]) begin n_err++; $display("FAIL dir%0d_ovf got %b want %b", i, ovf, eo[i]); end
            n_cmp++; if (lat != ref_lat(tb_[i])) begin n_err++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, ref_lat(tb_[i])); end
            n_cmp++; if (bb != 0) begin n_err++; $display("FAIL dir%0d_busy bad cycles %0d want 0", i, bb); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] x, y;
        logic [127:0] p;
        int lat, bb;
        for (int i = 0; i < 24; i++) begin
            x = rand_op(); y = rand_op();
            p = ref_prod(x, y);
            do_op(x, y, lat, bb);
            n_cmp++; if ({prod_hi, prod} !== p) begin n_err++; $display("FAIL rnd%0d_prod a=%h b=%h got %h want %h", i, x, y, {prod_hi, prod}, p); end
            n_cmp++; if (ovf !== ref_ovf(p)) begin n_err++; $display("FAIL rnd%0d_ovf got %b want %b", i, ovf, ref_ovf(p)); end
            n_cmp++; if (lat != ref_lat(y) || bb != 0) begin n_err++; $display("FAIL rnd%0d_timing lat %0d want %0d busy_bad %0d", i, lat, ref_lat(y), bb); end
        end
    endtask

    task automatic test_hold();
        logic [127:0] p;
        int lat, bb;
        p = ref_prod(64'd1000, -64'sd3);
        do_op(64'd1000, -64'sd3, lat, bb);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL hold%0d_done got %b want 0", i, done); end
            n_cmp++; if ({prod_hi, prod} !== p) begin n_err++; $display("FAIL hold%0d_prod got %h want %h", i, {prod_hi, prod}, p); end
        end
    endtask

    task automatic test_ignore_start();
        int ndone, dcyc;
        a = 64'd4; b = 64'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; ndone = 0; dcyc = -1;
        for (int cyc = 1; cyc <= 90; cyc++) begin
            if (cyc == 10 || cyc == 30) begin
                a = {$urandom(), $urandom()}; b = 64'd9; start = 1'b1;
            end else begin
                start = 1'b0;
                a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()};
            end
            @(posedge clk); #1;
            if (done === 1'b1) begin
                ndone++; dcyc = cyc;
                n_cmp++; if ({prod_hi, prod} !== 128'd16) begin n_err++; $display("FAIL ignore_prod got %h want 16", {prod_hi, prod}); end
            end
        end
        start = 1'b0;
        n_cmp++; if (ndone != 1) begin n_err++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
        n_cmp++; if (dcyc != ref_lat(64'd4)) begin n_err++; $display("FAIL ignore_latency got %0d want %0d", dcyc, ref_lat(64'd4)); end
    endtask

    task automatic test_abort();
        int ndone;
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h7FFF_FFFF_FFFF_FFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
        n_cmp++; if ({prod_hi, prod} !== 128'd0) begin n_err++; $display("FAIL abort_prod got %h want 0", {prod_hi, prod}); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL abort_ovf got %b want 0", ovf); end
        ndone = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        n_cmp++; if (ndone != 0) begin n_err++; $display("FAIL abort_no_done got %0d pulses want 0", ndone); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x1, y1, x2, y2;
        logic [127:0] p2;
        int lat, bb;
        for (int k = 0; k < 3; k++) begin
            x1 = rand_op(); y1 = rand_op(); x2 = rand_op(); y2 = rand_op();
            p2 = ref_prod(x2, y2);
            do_op(x1, y1, lat, bb);
            n_cmp++; if ({prod_hi, prod} !== ref_prod(x1, y1)) begin n_err++; $display("FAIL b2b%0d_first got %h want %h", k, {prod_hi, prod}, ref_prod(x1, y1)); end
            // Still in the done cycle: re-issue immediately.
            do_op(x2, y2, lat, bb);
            n_cmp++; if ({prod_hi, prod} !== p2) begin n_err++; $display("FAIL b2b%0d_second got %h want %h", k, {prod_hi, prod}, p2); end
            n_cmp++; if (lat != ref_lat(y2) || bb != 0) begin n_err++; $display("FAIL b2b%0d_timing lat %0d want %0d busy_bad %0d", k, lat, ref_lat(y2), bb); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
